// File: rtl/vector_store_sequencer_pkg.sv
// Shared types and sizing for the vector store/load sequencer.
package cpu_vec_pkg;

    localparam int LANES      = 16;
    localparam int LANE_W     = 8;
    localparam int VEC_W      = 128;
    localparam int RAM_ADDR_W = 12;
    localparam int LANE_IDX_W = 4;
    localparam int MAX_RD_LAT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STORE = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } seq_state_t;

    // Index of the final lane for a vector of n lanes.
    function automatic logic [LANE_IDX_W-1:0] last_lane(input int n);
        return LANE_IDX_W'(n - 1);
    endfunction

endpackage

// File: rtl/vector_store_sequencer_if.sv
// Request, response and byte-RAM signals of the sequencer, bundled.
// slave = sequencer side, master = pipeline/RAM side.
interface vector_store_sequencer_if #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 12
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_load;
    logic [ADDR_W-1:0]    req_addr;
    logic [8*LANES-1:0]   req_data;

    logic [ADDR_W-1:0]    ram_addr;
    logic [7:0]           ram_wdata;
    logic                 ram_wren;
    logic [7:0]           ram_rdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [8*LANES-1:0]   rsp_data;

    logic                 busy;

    modport slave (
        input  req_valid, req_load, req_addr, req_data, ram_rdata, rsp_ready,
        output req_ready, ram_addr, ram_wdata, ram_wren, rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_load, req_addr, req_data, ram_rdata, rsp_ready,
        input  req_ready, ram_addr, ram_wdata, ram_wren, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/vector_store_sequencer_pipe.sv
// Tracks outstanding RAM reads: a valid bit and lane index per read,
// delayed by exactly the RAM read latency so the index lines up with
// the returning data.
module lane_delay_pipe
    import cpu_vec_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int IDX_W = LANE_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             pending
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Shift register; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            idx_q[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // Reads still travelling behind the output stage; when clear, the
    // read at the output (if any) is the last one.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | vld_q[i];
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/vector_store_sequencer.sv
// Serialises a vector store (scatter) or load (gather) onto a single
// byte-wide RAM port, one lane per cycle, then presents the vector as a
// response until the consumer takes it.
//
//   state | meaning
//   IDLE  | ready for a request
//   STORE | writing one lane per cycle
//   LOAD  | issuing one read address per cycle
//   DRAIN | waiting for outstanding read data to return
//   RESP  | holding rsp_valid/rsp_data until rsp_ready
module vector_store_sequencer
    import cpu_vec_pkg::*;
#(
    parameter int LANES      = cpu_vec_pkg::LANES,
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    vector_store_sequencer_if.slave   bus
);

    seq_state_t               state_q;
    seq_state_t               state_d;
    logic [ADDR_W-1:0]        addr_q;
    logic [8*LANES-1:0]       data_q;
    logic [LANE_IDX_W-1:0]    lane_q;

    logic                     lane_is_last;
    logic                     accept;
    logic [ADDR_W-1:0]        lane_addr;
    logic [7:0]               lane_byte;

    logic                     rd_issue;
    logic                     rd_valid;
    logic [LANE_IDX_W-1:0]    rd_idx;
    logic                     rd_pending;

    logic                     req_ready_c;
    logic [ADDR_W-1:0]        ram_addr_c;
    logic [7:0]               ram_wdata_c;
    logic                     ram_wren_c;
    logic                     rsp_valid_c;

    assign lane_is_last = (lane_q == last_lane(LANES));
    assign accept       = bus.req_valid && req_ready_c;
    // Wraps naturally at 2^ADDR_W.
    assign lane_addr    = addr_q + ADDR_W'(lane_q);
    assign lane_byte    = data_q[{lane_q, 3'b000} +: 8];
    assign rd_issue     = (state_q == LOAD);

    lane_delay_pipe #(
        .DEPTH (RAM_RD_LAT),
        .IDX_W (LANE_IDX_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_issue),
        .in_idx    (lane_q),
        .out_valid (rd_valid),
        .out_idx   (rd_idx),
        .pending   (rd_pending)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)          state_d = bus.req_load ? LOAD : STORE;
            STORE:   if (lane_is_last)    state_d = RESP;
            LOAD:    if (lane_is_last)    state_d = DRAIN;
            DRAIN:   if (!rd_pending)     state_d = RESP;
            RESP:    if (bus.rsp_ready)   state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Lane counter: restarts on every accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
        end else if (accept) begin
            lane_q <= '0;
        end else if (state_q == STORE || state_q == LOAD) begin
            lane_q <= lane_is_last ? '0 : lane_q + 1'b1;
        end
    end

    // Request capture and gather write-back; one vector register serves
    // as store source, load destination and response payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            addr_q <= bus.req_addr;
            data_q <= bus.req_data;
        end else if (rd_valid) begin
            data_q[{rd_idx, 3'b000} +: 8] <= bus.ram_rdata;
        end
    end

    // Outputs decoded from state; reset forces everything quiet even in
    // the cycle before the reset edge so an interrupted store stops at once.
    always_comb begin
        req_ready_c = 1'b0;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        ram_wren_c  = 1'b0;
        rsp_valid_c = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:  req_ready_c = 1'b1;
                STORE: begin
                    ram_addr_c  = lane_addr;
                    ram_wdata_c = lane_byte;
                    ram_wren_c  = 1'b1;
                end
                LOAD:  ram_addr_c  = lane_addr;
                RESP:  rsp_valid_c = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_wdata = ram_wdata_c;
    assign bus.ram_wren  = ram_wren_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = reset ? '0 : data_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vector_store_sequencer.sv
// Scoreboard bench: two sequencers (read latency 1 and 3), each with a
// byte-RAM model. Stimulus pushes expected writes/responses; a negedge
// monitor pops and compares whenever a DUT writes or responds.
module tb_vector_store_sequencer;
    import cpu_vec_pkg::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vector_store_sequencer_if #(.LANES(16), .ADDR_W(12)) ifa ();
    vector_store_sequencer_if #(.LANES(16), .ADDR_W(12)) ifb ();

    vector_store_sequencer #(.LANES(16), .ADDR_W(12), .RAM_RD_LAT(LAT_A)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    vector_store_sequencer #(.LANES(16), .ADDR_W(12), .RAM_RD_LAT(LAT_B)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    // RAM models
    logic [7:0]  mem_a [4096] = '{default: 8'h00};
    logic [7:0]  mem_b [4096] = '{default: 8'h00};
    logic [11:0] rd_a [LAT_A] = '{default: 12'h000};
    logic [11:0] rd_b [LAT_B] = '{default: 12'h000};

    always @(posedge clk) begin
        if (ifa.ram_wren) mem_a[ifa.ram_addr] <= ifa.ram_wdata;
        rd_a[0] <= ifa.ram_addr;
        for (int i = 1; i < LAT_A; i++) rd_a[i] <= rd_a[i-1];
    end
    assign ifa.ram_rdata = mem_a[rd_a[LAT_A-1]];

    always @(posedge clk) begin
        if (ifb.ram_wren) mem_b[ifb.ram_addr] <= ifb.ram_wdata;
        rd_b[0] <= ifb.ram_addr;
        for (int i = 1; i < LAT_B; i++) rd_b[i] <= rd_b[i-1];
    end
    assign ifb.ram_rdata = mem_b[rd_b[LAT_B-1]];

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t  exp_wr  [2][$];
    rsp_t exp_rsp [2][$];
    int   t0 [2] = '{0, 0};
    bit   prev_vld [2] = '{1'b0, 1'b0};
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] base);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic expect_store(input int d, input logic [11:0] a, input logic [127:0] v);
        wr_t  w;
        rsp_t r;
        for (int i = 0; i < 16; i++) begin
            w.addr = a + 12'(i);
            w.data = v[i*8 +: 8];
            w.cyc  = i + 1;
            exp_wr[d].push_back(w);
        end
        r.data = v;
        r.cyc  = 17;
        exp_rsp[d].push_back(r);
    endtask

    task automatic expect_rsp(input int d, input logic [127:0] v, input int c);
        rsp_t r;
        r.data = v;
        r.cyc  = c;
        exp_rsp[d].push_back(r);
    endtask

    task automatic drive(input int d, input bit v, input bit ld, input logic [11:0] a,
                         input logic [127:0] dat);
        if (d == 0) begin
            ifa.req_valid = v; ifa.req_load = ld; ifa.req_addr = a; ifa.req_data = dat;
        end else begin
            ifb.req_valid = v; ifb.req_load = ld; ifb.req_addr = a; ifb.req_data = dat;
        end
    endtask

    // Offers a request and returns just after the accepting edge.
    task automatic send(input int d, input bit ld, input logic [11:0] a, input logic [127:0] dat);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        @(posedge clk); #1;
        drive(d, 1'b1, ld, a, dat);
        while (n < 100) begin
            if ((d == 0) ? ifa.req_ready : ifb.req_ready) begin
                @(posedge clk); #1;
                t0[d] = cyc;
                drive(d, 1'b0, 1'b0, 12'h000, '0);
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout dut%0d: got no req_ready expected ready within 100 cycles", d);
            drive(d, 1'b0, 1'b0, 12'h000, '0);
        end
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while ((exp_rsp[d].size() != 0 || ((d == 0) ? ifa.busy : ifb.busy)) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout dut%0d: got busy after 200 cycles expected idle", d);
        end
    endtask

    // Monitor: scoreboard pops on every RAM write and every valid response.
    always @(negedge clk) begin
        logic        wren_s [2];
        logic [11:0] addr_s [2];
        logic [7:0]  wdat_s [2];
        logic        rdy_s  [2];
        logic        busy_s [2];
        logic        rv_s   [2];
        logic        rr_s   [2];
        logic [127:0] rd_s  [2];
        wr_t         e;
        int          rel;
        wren_s[0] = ifa.ram_wren;  wren_s[1] = ifb.ram_wren;
        addr_s[0] = ifa.ram_addr;  addr_s[1] = ifb.ram_addr;
        wdat_s[0] = ifa.ram_wdata; wdat_s[1] = ifb.ram_wdata;
        rdy_s[0]  = ifa.req_ready; rdy_s[1]  = ifb.req_ready;
        busy_s[0] = ifa.busy;      busy_s[1] = ifb.busy;
        rv_s[0]   = ifa.rsp_valid; rv_s[1]   = ifb.rsp_valid;
        rr_s[0]   = ifa.rsp_ready; rr_s[1]   = ifb.rsp_ready;
        rd_s[0]   = ifa.rsp_data;  rd_s[1]   = ifb.rsp_data;
        for (int d = 0; d < 2; d++) begin
            rel = cyc - t0[d] + 1;
            if (wren_s[d]) begin
                if (exp_wr[d].size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write dut%0d: got write %h<=%h expected none", d, addr_s[d], wdat_s[d]);
                end else begin
                    e = exp_wr[d].pop_front();
                    check("wr_addr", 128'(addr_s[d]), 128'(e.addr));
                    check("wr_data", 128'(wdat_s[d]), 128'(e.data));
                    check("wr_cycle", 128'(rel), 128'(e.cyc));
                end
            end
            if (reset) begin
                check("ready_in_reset", 128'(rdy_s[d]), 128'(0));
                prev_vld[d] = 1'b0;
            end else begin
                check("ready_vs_busy", 128'(rdy_s[d]), 128'(!busy_s[d]));
                if (rv_s[d]) begin
                    if (exp_rsp[d].size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_rsp dut%0d: got rsp_valid data %h expected none", d, rd_s[d]);
                    end else begin
                        if (!prev_vld[d]) check("rsp_cycle", 128'(rel), 128'(exp_rsp[d][0].cyc));
                        check("rsp_data", rd_s[d], exp_rsp[d][0].data);
                        if (rr_s[d]) void'(exp_rsp[d].pop_front());
                    end
                end
                prev_vld[d] = rv_s[d] && !rr_s[d];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int old_t0;
        int n;
        drive(0, 1'b0, 1'b0, 12'h000, '0);
        drive(1, 1'b0, 1'b0, 12'h000, '0);
        ifa.rsp_ready = 1'b1;
        ifb.rsp_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",     128'(ifa.req_ready), 128'(0));
        check("rst_wren",      128'(ifa.ram_wren),  128'(0));
        check("rst_ram_addr",  128'(ifa.ram_addr),  128'(0));
        check("rst_ram_wdata", 128'(ifa.ram_wdata), 128'(0));
        check("rst_rsp_valid", 128'(ifa.rsp_valid), 128'(0));
        check("rst_rsp_data",  ifa.rsp_data,        128'(0));
        check("rst_busy",      128'(ifa.busy),      128'(0));
        check("rst_busy_b",    128'(ifb.busy),      128'(0));
        reset = 1'b0;
        #1;
        check("idle_ready", 128'(ifa.req_ready), 128'(1));

        // Store base 0x010, byte i = i.
        expect_store(0, 12'h010, ramp(8'h00));
        send(0, 1'b0, 12'h010, ramp(8'h00));
        wait_done(0);

        // Load it back, latency 1.
        expect_rsp(0, 128'h0F0E0D0C0B0A09080706050403020100, 18);
        send(0, 1'b1, 12'h010, '0);
        wait_done(0);

        // Store across the top of the address space.
        expect_store(0, 12'hFFA, ramp(8'hA0));
        send(0, 1'b0, 12'hFFA, ramp(8'hA0));
        wait_done(0);
        check("wrap_mem_fff", 128'(mem_a[12'hFFF]), 128'(8'hA5));
        check("wrap_mem_000", 128'(mem_a[12'h000]), 128'(8'hA6));
        check("wrap_mem_009", 128'(mem_a[12'h009]), 128'(8'hAF));

        expect_rsp(0, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 18);
        send(0, 1'b1, 12'hFFA, '0);
        wait_done(0);

        // Reset during store lane 7: only lanes 0..6 may be written.
        begin
            wr_t w;
            for (int i = 0; i < 7; i++) begin
                w.addr = 12'h100 + 12'(i);
                w.data = 8'h20 + 8'(i);
                w.cyc  = i + 1;
                exp_wr[0].push_back(w);
            end
        end
        send(0, 1'b0, 12'h100, ramp(8'h20));
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("abort_wren", 128'(ifa.ram_wren), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_ready",     128'(ifa.req_ready), 128'(1));
        check("abort_busy",      128'(ifa.busy),      128'(0));
        check("abort_rsp_valid", 128'(ifa.rsp_valid), 128'(0));
        repeat (3) begin @(posedge clk); #1; end
        check("abort_mem_106", 128'(mem_a[12'h106]), 128'(8'h26));
        check("abort_mem_107", 128'(mem_a[12'h107]), 128'(8'h00));
        check("abort_mem_10f", 128'(mem_a[12'h10F]), 128'(8'h00));
        check("abort_wr_left", 128'(exp_wr[0].size()), 128'(0));

        // Back-pressured load with a second request offered while busy.
        ifa.rsp_ready = 1'b0;
        expect_rsp(0, 128'h0F0E0D0C0B0A09080706050403020100, 18);
        send(0, 1'b1, 12'h010, '0);
        old_t0 = t0[0];
        expect_store(0, 12'h200, ramp(8'h60));
        drive(0, 1'b1, 1'b0, 12'h200, ramp(8'h60));
        n = 0;
        while (!ifa.rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("bp_valid_seen", 128'(ifa.rsp_valid), 128'(1));
        repeat (5) begin @(posedge clk); #1; end
        ifa.rsp_ready = 1'b1;
        send(0, 1'b0, 12'h200, ramp(8'h60));
        check("bp_second_accept_edge", 128'(t0[0] - old_t0), 128'(24));
        wait_done(0);

        // Latency-3 instance: store then gather.
        expect_store(1, 12'h040, ramp(8'h50));
        send(1, 1'b0, 12'h040, ramp(8'h50));
        wait_done(1);
        expect_rsp(1, 128'h5F5E5D5C5B5A59585756555453525150, 20);
        send(1, 1'b1, 12'h040, '0);
        wait_done(1);

        repeat (2) begin @(posedge clk); #1; end
        check("left_wr_a",  128'(exp_wr[0].size()),  128'(0));
        check("left_rsp_a", 128'(exp_rsp[0].size()), 128'(0));
        check("left_wr_b",  128'(exp_wr[1].size()),  128'(0));
        check("left_rsp_b", 128'(exp_rsp[1].size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vector_store_sequencer.md
VECTOR_STORE_SEQUENCER -- requirements
Module: vector_store_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 16: number of 8-bit lanes per vector.
REQ-002 SHALL have parameter ADDR_W, default 12: data RAM byte-address width.
REQ-003 SHALL have parameter RAM_RD_LAT, default 1, legal range 1..4: RAM read latency in cycles.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  vector memory request offered.
REQ-007 req_ready  output  1  request accepted when high together with req_valid.
REQ-008 req_load  input  1  1 = vector load (gather), 0 = vector store (scatter).
REQ-009 req_addr  input  ADDR_W  base byte address.
REQ-010 req_data  input  8*LANES  store data; lane i = bits [8i+7:8i].
REQ-011 ram_addr  output  ADDR_W  byte address to the RAM port.
REQ-012 ram_wdata  output  8  byte written to the RAM.
REQ-013 ram_wren  output  1  RAM write enable.
REQ-014 ram_rdata  input  8  RAM read data, valid RAM_RD_LAT cycles after its address.
REQ-015 rsp_valid  output  1  operation complete; rsp_data valid.
REQ-016 rsp_ready  input  1  consumer accepts the response.
REQ-017 rsp_data  output  8*LANES  gathered vector on load; captured store data on store.
REQ-018 busy  output  1  stall to the pipeline; high whenever state != IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, STORE, LOAD, DRAIN, RESP.
REQ-020 IDLE: req_ready=1; on req_valid&&req_ready, capture addr/data/kind; next state STORE (req_load=0) or LOAD (req_load=1).
REQ-021 STORE: one lane per cycle, lane i=0..LANES-1: ram_addr=req_addr+i, ram_wdata=lane i, ram_wren=1; after lane LANES-1 -> RESP.
REQ-022 LOAD: one read address per cycle, ram_addr=req_addr+i, ram_wren=0; after lane LANES-1 -> DRAIN.
REQ-023 Each read SHALL be tracked by a RAM_RD_LAT-deep valid/lane-index pipe; returning ram_rdata SHALL be written into rsp_data lane at the tracked index.
REQ-024 DRAIN: wait until the pipe is empty, then -> RESP; last byte captured on the edge entering RESP.
REQ-025 RESP: rsp_valid=1 and rsp_data held stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE.
REQ-026 Address arithmetic SHALL be modulo 2^ADDR_W (0xFFF+1 wraps to 0x000).
REQ-027 Latency (store, request accepted at edge 0): writes in cycles 1..16, rsp_valid from cycle 17.
REQ-028 Latency (load, RAM_RD_LAT=1): reads in cycles 1..16, rsp_valid from cycle 18.
REQ-029 req_ready SHALL be 0 in every state except IDLE; req_valid in other states SHALL be ignored, not queued.
REQ-030 A new request SHALL NOT be accepted in the same cycle as the RESP handshake; earliest acceptance is the following cycle.
REQ-031 ram_wren SHALL be 0 in every state except STORE.
REQ-032 busy = (state != IDLE).

Reset
REQ-033 While reset is high: state IDLE, req_ready=0, ram_wren=0, rsp_valid=0, ram_addr=0, ram_wdata=0, rsp_data=0, lane counter 0, read pipe cleared.
REQ-034 Reset mid-operation SHALL abort it: no RAM write in any cycle after the reset edge, and in-flight read data is discarded.

Structure
REQ-035 Shared package cpu_vec_pkg SHALL hold LANES, LANE_W=8, VEC_W=128, RAM_ADDR_W=12 and the FSM state enum.
REQ-036 The read-latency tracker SHALL be a sub-module named lane_delay_pipe (valid + 4-bit lane index, depth RAM_RD_LAT).

Verification
REQ-037 Store base 0x010, byte i = i -> ram_wren cycles 1..16, addresses 0x010..0x01F with data 0x00..0x0F, rsp_valid at cycle 17.
REQ-038 Then load base 0x010 (RAM model, latency 1) -> rsp_data = 0x0F0E0D0C0B0A09080706050403020100, rsp_valid at cycle 18.
REQ-039 Store base 0xFFA -> addresses 0xFFA..0xFFF, then 0x000..0x009.
REQ-040 Reset asserted during store lane 7 -> ram_wren 0 from the next cycle, lanes 7..15 never written, rsp_valid 0; idle state with req_ready=1 after reset release.
REQ-041 Load with rsp_ready held low for 5 cycles, plus a second req_valid during busy -> rsp_valid and rsp_data stable throughout, req_ready 0, second request not accepted until the cycle after the handshake.
REQ-042 Load with RAM_RD_LAT=3 -> correct lane ordering in rsp_data, rsp_valid at cycle 20.
